// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with double-buffered duty levels.
// A new level is applied only at a period wrap, or at once while idle.
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 4,
    parameter bit          INVERT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    input  logic       load,
    input  logic       enable,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       frame_start,
    output logic       pending
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    // Channel index 2 = red, 1 = green, 0 = blue
    logic [2:0][7:0] rgb_in;
    logic [2:0][7:0] act_q, act_d;
    logic [2:0][7:0] pend_q, pend_d;
    logic            pflag_q, pflag_d;
    logic [15:0]     presc_q, presc_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            frame_q, frame_d;
    logic [2:0]      pwm_q, pwm_d;
    logic            tick;
    logic            wrap;

    assign rgb_in = {R, G, B};

    always_comb begin
        presc_d = '0;
        cnt_d   = '0;
        tick    = 1'b0;
        wrap    = 1'b0;
        frame_d = 1'b0;
        pwm_d   = {3{INVERT}};
        act_d   = act_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;

        if (enable) begin
            tick    = (presc_q == PRESC_LAST);
            presc_d = tick ? '0 : presc_q + 16'd1;
            cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
            wrap    = tick && (cnt_q == 8'hFF);
            frame_d = wrap;
            // Full scale is forced on so duty 255 has no one-tick dropout
            for (int unsigned i = 0; i < 3; i++) begin
                pwm_d[i] = ((act_q[i] == 8'hFF) || (cnt_q < act_q[i])) ^ INVERT;
            end
        end

        if (load && wrap) begin
            act_d   = rgb_in;
            pflag_d = 1'b0;
        end else begin
            // Idle has no period in progress, so pending levels move over at once
            if ((wrap || !enable) && pflag_q) begin
                act_d   = pend_q;
                pflag_d = 1'b0;
            end
            if (load) begin
                pend_d  = rgb_in;
                pflag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
            pend_q  <= '0;
            pflag_q <= 1'b0;
            frame_q <= 1'b0;
            pwm_q   <= {3{INVERT}};
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            frame_q <= frame_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_r       = pwm_q[2];
    assign pwm_g       = pwm_q[1];
    assign pwm_b       = pwm_q[0];
    assign frame_start = frame_q;
    assign pending     = pflag_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: two instances (PRESCALE=1 non-inverted,
// PRESCALE=4 inverted) share stimulus and are checked against a period-level model.
module tb_rgb_pwm_driver;

    localparam int unsigned P0 = 1;
    localparam bit          I0 = 1'b0;
    localparam int unsigned P1 = 4;
    localparam bit          I1 = 1'b1;

    typedef struct packed {
        logic [2:0] pwm;
        logic       fs;
        logic       pend;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] R = '0, G = '0, B = '0;
    logic       load = 1'b0;
    logic       enable = 1'b0;
    logic       pwm_r0, pwm_g0, pwm_b0, fs0, pend0;
    logic       pwm_r1, pwm_g1, pwm_b1, fs1, pend1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Model state: enabled-cycle position since the period began, duties, pending flag
    int unsigned m_pos  [2];
    logic [7:0]  m_act  [2][3];
    logic [7:0]  m_pend [2][3];
    bit          m_flag [2];

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(P0), .INVERT(I0)) dut0 (
        .clk(clk), .rst_n(rst_n), .R(R), .G(G), .B(B), .load(load), .enable(enable),
        .pwm_r(pwm_r0), .pwm_g(pwm_g0), .pwm_b(pwm_b0), .frame_start(fs0), .pending(pend0)
    );

    rgb_pwm_driver #(.PRESCALE(P1), .INVERT(I1)) dut1 (
        .clk(clk), .rst_n(rst_n), .R(R), .G(G), .B(B), .load(load), .enable(enable),
        .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1), .frame_start(fs1), .pending(pend1)
    );

    // Expected outputs after the coming clock edge, given the inputs driven for it
    function automatic exp_t model_step(input int k, input bit rn, input bit en, input bit ld,
                                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t        e;
        int unsigned p;
        bit          inv;
        int unsigned cnt;
        bit          wrap;
        logic [7:0]  lv [3];
        p     = (k == 0) ? P0 : P1;
        inv   = (k == 0) ? I0 : I1;
        lv[0] = r;
        lv[1] = g;
        lv[2] = b;
        e     = '0;
        if (!rn) begin
            m_pos[k]  = 0;
            m_flag[k] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_act[k][i]  = '0;
                m_pend[k][i] = '0;
            end
            e.pwm = {3{inv}};
            return e;
        end
        if (!en) begin
            if (m_flag[k]) begin
                for (int i = 0; i < 3; i++) m_act[k][i] = m_pend[k][i];
                m_flag[k] = 1'b0;
            end
            if (ld) begin
                for (int i = 0; i < 3; i++) m_pend[k][i] = lv[i];
                m_flag[k] = 1'b1;
            end
            m_pos[k] = 0;
            e.pwm    = {3{inv}};
            e.pend   = m_flag[k];
            return e;
        end
        cnt  = (m_pos[k] / p) % 256;
        wrap = ((m_pos[k] % p) == p - 1) && (cnt == 255);
        for (int i = 0; i < 3; i++) begin
            e.pwm[2 - i] = ((m_act[k][i] == 8'd255) || (cnt < m_act[k][i])) ^ inv;
        end
        e.fs = wrap;
        if (wrap && ld) begin
            for (int i = 0; i < 3; i++) m_act[k][i] = lv[i];
            m_flag[k] = 1'b0;
        end else if (ld) begin
            for (int i = 0; i < 3; i++) m_pend[k][i] = lv[i];
            m_flag[k] = 1'b1;
        end else if (wrap && m_flag[k]) begin
            for (int i = 0; i < 3; i++) m_act[k][i] = m_pend[k][i];
            m_flag[k] = 1'b0;
        end
        m_pos[k] = m_pos[k] + 1;
        e.pend   = m_flag[k];
        return e;
    endfunction

    task automatic cyc(input bit rn, input bit en, input bit ld,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        rst_n  = rn;
        enable = en;
        load   = ld;
        R      = r;
        G      = g;
        B      = b;
        q0.push_back(model_step(0, rn, en, ld, r, g, b));
        q1.push_back(model_step(1, rn, en, ld, r, g, b));
    endtask

    task automatic run(input bit en, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b1, en, 1'b0, 8'hA5, 8'h5A, 8'h3C);
    endtask

    task automatic chk(input string nm, input logic [2:0] pw, input logic fs, input logic pd,
                       input exp_t e);
        checks++;
        if (pw !== e.pwm) begin
            errors++;
            $display("FAIL %s pwm act=%b req=%b t=%0t", nm, pw, e.pwm, $time);
        end
        checks++;
        if (fs !== e.fs) begin
            errors++;
            $display("FAIL %s frame_start act=%b req=%b t=%0t", nm, fs, e.fs, $time);
        end
        checks++;
        if (pd !== e.pend) begin
            errors++;
            $display("FAIL %s pending act=%b req=%b t=%0t", nm, pd, e.pend, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge per instance
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("p1", {pwm_r0, pwm_g0, pwm_b0}, fs0, pend0, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("p4inv", {pwm_r1, pwm_g1, pwm_b1}, fs1, pend1, e);
        end
    end

    function automatic logic [7:0] rnd_level();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd1;
            3:       return 8'd254;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit          en_r;
        bit          ld_r;
        bit          rn_r;

        // Reset, then load 64/0/255 while idle and run
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        run(1'b0, 2);
        cyc(1'b1, 1'b0, 1'b1, 8'd64, 8'd0, 8'd255);
        run(1'b0, 2);
        run(1'b1, 1100);

        // Red 128 for a period, then 32 loaded at cnt=10
        cyc(1'b1, 1'b1, 1'b1, 8'd128, 8'd0, 8'd255);
        while (m_pos[0] % 256 != 255) run(1'b1, 1);
        run(1'b1, 1);
        while (m_pos[0] % 256 != 10) run(1'b1, 1);
        cyc(1'b1, 1'b1, 1'b1, 8'd32, 8'd0, 8'd255);
        run(1'b1, 600);

        // Bypass load exactly on the wrap of each instance
        while (m_pos[0] % 256 != 255) run(1'b1, 1);
        cyc(1'b1, 1'b1, 1'b1, 8'd200, 8'd17, 8'd254);
        run(1'b1, 300);
        while (m_pos[1] % 1024 != 1023) run(1'b1, 1);
        cyc(1'b1, 1'b1, 1'b1, 8'd1, 8'd128, 8'd254);
        run(1'b1, 1100);

        // Reset mid-period with a load pending, then run with no load
        while (m_pos[0] % 256 != 100) run(1'b1, 1);
        cyc(1'b1, 1'b1, 1'b1, 8'd77, 8'd255, 8'd9);
        run(1'b1, 3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        run(1'b1, 1100);

        // Back-to-back loads, last wins; then enable dropped mid-period
        cyc(1'b1, 1'b1, 1'b1, 8'd10, 8'd10, 8'd10);
        run(1'b1, 5);
        cyc(1'b1, 1'b1, 1'b1, 8'd20, 8'd20, 8'd20);
        run(1'b1, 1100);
        while (m_pos[0] % 256 != 15) run(1'b1, 1);
        run(1'b0, 5);
        run(1'b1, 1100);

        // Randomised traffic
        en_r = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 499) == 0) en_r = ~en_r;
            ld_r = ($urandom_range(0, 59) == 0);
            rn_r = ($urandom_range(0, 2999) != 0);
            cyc(rn_r, en_r, ld_r, rnd_level(), rnd_level(), rnd_level());
        end
        run(1'b1, 4);

        @(posedge clk);
        #3;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d/%0d req=0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Three-channel PWM driver sitting directly downstream of the HSV-to-RGB converter.
- Takes the converter's 8-bit R, G, B levels and drives the RGB LED pins with a proportional duty cycle.
- New levels are double-buffered and applied only at a PWM period boundary, so a colour change never produces a glitched partial period.

Parameters:
- PRESCALE, 4, clk cycles per PWM tick; integer 1..65535.
- INVERT, 0, 1 = active-low LED outputs; all three outputs inverted, including their reset/idle level.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- R  input  8  red level from the HSV-to-RGB converter.
- G  input  8  green level.
- B  input  8  blue level.
- load  input  1  one-cycle strobe: capture R/G/B into the pending registers.
- enable  input  1  1 = PWM running; 0 = idle.
- pwm_r  output  1  red LED drive.
- pwm_g  output  1  green LED drive.
- pwm_b  output  1  blue LED drive.
- frame_start  output  1  one-cycle pulse at each PWM period wrap.
- pending  output  1  captured levels are waiting to be applied.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Prescaler, tick counter cnt, active duties, pending duties all 0.
  - pending=0, frame_start=0.
  - pwm_* = INVERT (inactive level).
  - Reset takes priority over every other input; a period in progress is abandoned.
- Prescaler (enable=1):
  - Counts 0..PRESCALE-1; tick asserted in the cycle it equals PRESCALE-1, then it returns to 0.
  - PRESCALE=1 gives a tick every cycle.
- Tick counter:
  - 8-bit cnt increments on each tick; wraps 255->0.
  - Period = 256 ticks = 256*PRESCALE clk cycles.
- Wrap event: tick while cnt==255. In that cycle:
  - cnt<=0 and frame_start<=1 for exactly one cycle.
  - If pending=1: active<=pending duties, pending<=0.
- Load:
  - load=1 captures R,G,B into the pending registers and sets pending<=1.
  - A second load before the wrap overwrites the pending values; last load wins.
- Load in the same cycle as a wrap: bypass.
  - Active takes the R,G,B present at load directly; pending<=0.
  - The new values govern the period starting at cnt=0.
- Compare (registered, one clk latency from cnt):
  - pwm_x <= (active_x==255) ? 1 : (cnt < active_x), then XOR with INVERT.
  - Duty 0 = always off.
  - Duty 255 = always on (full brightness, no one-tick dropout).
  - Duty d in 1..254 = on for d ticks out of 256, starting at cnt=0.
- enable=0:
  - Prescaler and cnt forced to 0; pwm_* = INVERT; frame_start=0.
  - load is still accepted. While idle, a captured value transfers to active on the next cycle and pending clears, since no period is in progress.
- enable 0->1:
  - Period starts at cnt=0 with the current active duties.
  - First frame_start occurs after 256*PRESCALE cycles.
- Widths:
  - Comparison is unsigned 8-bit.
  - Prescaler is 16-bit; no arithmetic overflow is possible.
- Channels are independent; identical duties give bit-identical outputs in the same cycle.

Test Plan:
1. Reset, then PRESCALE=1, enable=1, load R=64, G=0, B=255 while idle (enable=0 first) -> each period: pwm_r high 64 cycles, low 192; pwm_g constantly 0; pwm_b constantly 1; frame_start pulses every 256 cycles.
2. Running with R=128; load R=32 at cnt=10 -> pending=1; current period keeps 128-cycle high; at wrap pending=0 and the next period has a 32-cycle high; no intermediate width ever appears.
3. Load R=200 in the exact wrap cycle -> bypass: next period high 200 ticks; pending never asserts.
4. PRESCALE=4, INVERT=1, R=1 -> pwm_r low for 4 clk, high for 1020 clk per period; after reset, pwm_r=1.
5. rst_n=0 asserted mid-period with pending=1 -> next cycle all outputs inactive, pending=0, cnt=0; after release, outputs stay inactive until a load.
6. Back-to-back loads R=10, then R=20 before wrap -> only 20 is applied; enable dropped mid-period -> outputs inactive the following cycle; cnt restarts at 0 on re-enable.
